demux_stream_ctrl: RTL and testbench
====================================

Name: demux_stream_ctrl

Overview:
- Sequencing controller for the 1-bit two-way demux datapath (x → y0/y1 under sel).
- Parses a serial bit-stream packet: destination bit, then length field, then payload. Holds the route stable for the whole payload and steers the payload bits to output 0 or 1 with per-output valid/ready backpressure.
- Sits between a serial source and two serial sinks. Counts completed packets per destination.

Parameters:
- LEN_W, 4: width of the payload-length field, in bits; max payload = 2^LEN_W-1.
- CNT_W, 8: width of each per-destination packet counter; counters wrap.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to S_DEST next edge.
- in_valid  in  1  source bit valid.
- in_data  in  1  source bit (x).
- in_ready  out  1  block accepts in_data this cycle.
- y0_valid  out  1  payload bit valid on output 0.
- y0_data  out  1  payload bit to output 0.
- y0_ready  in  1  sink 0 ready.
- y1_valid  out  1  payload bit valid on output 1.
- y1_data  out  1  payload bit to output 1.
- y1_ready  in  1  sink 1 ready.
- sel  out  1  current route (registered destination bit).
- busy  out  1  high in S_LEN or S_PAY.
- pkt_done  out  1  one-cycle pulse after a packet completes.
- pkt_cnt0  out  CNT_W  packets completed to output 0.
- pkt_cnt1  out  CNT_W  packets completed to output 1.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid && ready. Upstream must not assert in_valid while rst_n is low.
- Reset (async, rst_n=0):
  - state=S_DEST; sel=0, len_q=0, bit_cnt=0, rem=0.
  - pkt_done=0, pkt_cnt0=pkt_cnt1=0.
  - y0_valid=y1_valid=0, busy=0, in_ready=1 (follows state).
- FSM states: S_DEST, S_LEN, S_PAY.
- S_DEST:
  - in_ready=1.
  - On transfer: sel<=in_data, bit_cnt<=0, go to S_LEN.
- S_LEN:
  - in_ready=1.
  - On each transfer: len_q<={len_q[LEN_W-2:0],in_data} (MSB first), bit_cnt++.
  - On the LEN_W-th transfer, let L = the assembled value:
    - L==0: go to S_DEST, pulse pkt_done, increment pkt_cnt[sel].
    - else: rem<=L, go to S_PAY.
- S_PAY:
  - Zero-latency combinational pass-through.
  - in_ready = sel ? y1_ready : y0_ready.
  - y<sel>_valid = in_valid; y<sel>_data = in_data.
  - Non-selected output: valid=0, data=0.
  - Each transfer: rem--. On the transfer with rem==1: go to S_DEST; next cycle pkt_done=1 and pkt_cnt[sel] increments.
- Outside S_PAY: y0_valid=y1_valid=0 and y0_data=y1_data=0.
- sel is stable from the destination transfer until the next destination transfer; it never changes in S_LEN or S_PAY.
- Counters wrap at 2^CNT_W-1 → 0. pkt_done is registered and is 0 in every cycle that is not immediately after a completion.
- flush:
  - Priority over any transfer in the same cycle.
  - Next edge: state=S_DEST, len_q=0, rem=0; counters and sel unchanged; no pkt_done.
  - During the flush cycle in_ready is still per current state, but the bit is discarded.
- Backpressure in S_PAY:
  - Selected ready low → in_ready low, no state change, no bit lost.
  - The non-selected ready is ignored.
- Async reset mid-packet aborts immediately to reset values; a partial packet is not counted.

Decomposition:
- Shared package demux_pkg:
  - state enum (S_DEST, S_LEN, S_PAY);
  - localparams DEST_Y0=1'b0, DEST_Y1=1'b1;
  - default LEN_W/CNT_W values.
- One natural sub-module: demux_1bit. It is instantiated for the steering, with x=in_data gated by the payload phase and sel=sel. The controller adds valid/ready routing around it.

Test Plan:
- Packet 1,0011,101 with both readies high → y1 sees 1,0,1 on 3 consecutive cycles; y0_valid never high; pkt_done pulses the cycle after the last bit; pkt_cnt1=1, pkt_cnt0=0.
- Packet 0,0100,1100 with y0_ready low for 2 cycles after the 2nd payload bit → in_ready low for those 2 cycles; y0 receives 1,1,0,0 intact; pkt_cnt0=1.
- Zero-length packet 1,0000 → no y*_valid; pkt_done pulses one cycle after the 4th length bit; pkt_cnt1 increments; next bit is treated as a destination.
- flush asserted after the 1st payload bit of 0,0011,… → state returns to S_DEST; no pkt_done; pkt_cnt0 unchanged; following packet 1,0001,1 routes correctly to y1.
- rst_n pulsed low mid-payload → all outputs and counters at reset values while low; after release, packet 0,0010,10 completes normally.
- CNT_W=2, five back-to-back zero-length packets to dest 0 → pkt_cnt0 goes 1,2,3,0,1.

Source files
------------

// File: rtl/demux_stream_ctrl_pkg.sv
// Shared types and defaults for the serial demux controller.
// Combinational package; no latency, no backpressure.
package demux_pkg;

    typedef enum logic [1:0] {
        S_DEST = 2'd0,
        S_LEN  = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    localparam logic DEST_Y0 = 1'b0;
    localparam logic DEST_Y1 = 1'b1;

    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/demux_stream_ctrl_if.sv
// Serial source and two serial sinks of the demux controller.
// Plain bundle of valid/ready bit streams; no storage.
interface demux_stream_ctrl_if;

    logic in_valid;
    logic in_data;
    logic in_ready;
    logic y0_valid;
    logic y0_data;
    logic y0_ready;
    logic y1_valid;
    logic y1_data;
    logic y1_ready;

    modport master (
        output in_valid, in_data, y0_ready, y1_ready,
        input  in_ready, y0_valid, y0_data, y1_valid, y1_data
    );

    modport slave (
        input  in_valid, in_data, y0_ready, y1_ready,
        output in_ready, y0_valid, y0_data, y1_valid, y1_data
    );

endinterface

// File: rtl/demux_stream_ctrl_demux_1bit.sv
// One-bit two-way demux: x goes to y0 when sel=0, to y1 when sel=1.
// Purely combinational; the idle output is held at 0.
module demux_1bit (
    input  logic x,
    input  logic sel,
    output logic y0,
    output logic y1
);

    assign y0 = x & ~sel;
    assign y1 = x &  sel;

endmodule

// File: rtl/demux_stream_ctrl.sv
// Parses dest/length/payload bit-stream packets and steers payload to y0 or y1.
// Payload is a zero-latency pass-through; the selected sink's ready stalls the source.
module demux_stream_ctrl
    import demux_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    demux_stream_ctrl_if.slave stream,
    output logic             sel,
    output logic             busy,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    localparam int BC_W = $clog2(LEN_W) + 1;
    localparam logic [BC_W-1:0] LAST_LEN_BIT = BC_W'(LEN_W - 1);

    state_t           state_q;
    logic             sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [LEN_W-1:0] rem_q;
    logic             pkt_done_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic pay_phase;
    logic sel_ready;
    logic in_ready_d;
    logic xfer;
    logic steer_x;
    logic steer_y0;
    logic steer_y1;

    assign pay_phase = (state_q == S_PAY);
    assign sel_ready = (sel_q == DEST_Y1) ? stream.y1_ready : stream.y0_ready;

    always_comb begin
        in_ready_d = 1'b1;
        if (pay_phase) begin
            in_ready_d = sel_ready;
        end
    end

    assign xfer  = stream.in_valid && in_ready_d;
    // MSB-first length assembly; the last shifted value decides zero-length vs payload.
    assign len_d = {len_q[LEN_W-2:0], stream.in_data};

    assign steer_x = stream.in_data & pay_phase;

    demux_1bit u_demux (
        .x   (steer_x),
        .sel (sel_q),
        .y0  (steer_y0),
        .y1  (steer_y1)
    );

    assign stream.in_ready = in_ready_d;
    assign stream.y0_valid = pay_phase && (sel_q == DEST_Y0) && stream.in_valid;
    assign stream.y1_valid = pay_phase && (sel_q == DEST_Y1) && stream.in_valid;
    assign stream.y0_data  = steer_y0;
    assign stream.y1_data  = steer_y1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_DEST;
            sel_q      <= DEST_Y0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            rem_q      <= '0;
            pkt_done_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            pkt_done_q <= 1'b0;
            if (flush) begin
                // The bit presented alongside flush is dropped; route and counters survive.
                state_q <= S_DEST;
                len_q   <= '0;
                rem_q   <= '0;
            end else if (xfer) begin
                unique case (state_q)
                    S_DEST: begin
                        sel_q     <= stream.in_data;
                        bit_cnt_q <= '0;
                        state_q   <= S_LEN;
                    end
                    S_LEN: begin
                        len_q     <= len_d;
                        bit_cnt_q <= bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == LAST_LEN_BIT) begin
                            if (len_d == '0) begin
                                state_q    <= S_DEST;
                                pkt_done_q <= 1'b1;
                                if (sel_q == DEST_Y1) cnt1_q <= cnt1_q + CNT_W'(1);
                                else                  cnt0_q <= cnt0_q + CNT_W'(1);
                            end else begin
                                rem_q   <= len_d;
                                state_q <= S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q    <= S_DEST;
                            pkt_done_q <= 1'b1;
                            if (sel_q == DEST_Y1) cnt1_q <= cnt1_q + CNT_W'(1);
                            else                  cnt0_q <= cnt0_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_DEST;
                endcase
            end
        end
    end

    assign sel      = sel_q;
    assign busy     = (state_q != S_DEST);
    assign pkt_done = pkt_done_q;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Directed bench for demux_stream_ctrl with hand-computed expectations.
module tb_demux_stream_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       flush2;
    logic       sel, busy, pkt_done;
    logic [7:0] pkt_cnt0, pkt_cnt1;
    logic       sel2, busy2, pkt_done2;
    logic [1:0] pkt_cnt0_2, pkt_cnt1_2;

    int n_chk  = 0;
    int n_pass = 0;

    logic s_rdy, s_y0v, s_y0d, s_y1v, s_y1d;

    demux_stream_ctrl_if sif ();
    demux_stream_ctrl_if sif2 ();

    demux_stream_ctrl #(.LEN_W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .stream   (sif),
        .sel      (sel),
        .busy     (busy),
        .pkt_done (pkt_done),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    demux_stream_ctrl #(.LEN_W(4), .CNT_W(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush2),
        .stream   (sif2),
        .sel      (sel2),
        .busy     (busy2),
        .pkt_done (pkt_done2),
        .pkt_cnt0 (pkt_cnt0_2),
        .pkt_cnt1 (pkt_cnt1_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    // Present one bit, snapshot the combinational outputs mid-cycle, then take the edge.
    task automatic cyc(input logic v, input logic d);
        sif.in_valid = v;
        sif.in_data  = d;
        @(negedge clk);
        s_rdy = sif.in_ready;
        s_y0v = sif.y0_valid;
        s_y0d = sif.y0_data;
        s_y1v = sif.y1_valid;
        s_y1d = sif.y1_data;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic v, input logic d);
        sif2.in_valid = v;
        sif2.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] len4;
        logic [3:0] pay4;
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        rst_n = 1'b0;
        flush = 1'b0;
        flush2 = 1'b0;
        sif.in_valid = 1'b0;  sif.in_data = 1'b0;
        sif.y0_ready = 1'b1;  sif.y1_ready = 1'b1;
        sif2.in_valid = 1'b0; sif2.in_data = 1'b0;
        sif2.y0_ready = 1'b1; sif2.y1_ready = 1'b1;

        #2;
        check("rst_sel",      32'(sel), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(pkt_done), 0);
        check("rst_cnt0",     32'(pkt_cnt0), 0);
        check("rst_cnt1",     32'(pkt_cnt1), 0);
        check("rst_in_ready", 32'(sif.in_ready), 1);
        check("rst_y0v",      32'(sif.y0_valid), 0);
        check("rst_y1v",      32'(sif.y1_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Packet 1,0011,101 with both sinks ready.
        cyc(1, 1);
        check("t1_dest_rdy", 32'(s_rdy), 1);
        check("t1_sel", 32'(sel), 1);
        check("t1_busy", 32'(busy), 1);
        len4 = 4'b0011;
        for (int i = 3; i >= 0; i--) begin
            cyc(1, len4[i]);
            check("t1_len_y1v", 32'(s_y1v), 0);
            check("t1_len_y1d", 32'(s_y1d), 0);
        end
        pay4 = 4'b0101;
        for (int i = 2; i >= 0; i--) begin
            check("t1_pre_done", 32'(pkt_done), 0);
            cyc(1, pay4[i]);
            check("t1_y1v", 32'(s_y1v), 1);
            check("t1_y1d", 32'(s_y1d), 32'(pay4[i]));
            check("t1_y0v", 32'(s_y0v), 0);
            check("t1_rdy", 32'(s_rdy), 1);
        end
        check("t1_done", 32'(pkt_done), 1);
        check("t1_cnt1", 32'(pkt_cnt1), 1);
        check("t1_cnt0", 32'(pkt_cnt0), 0);
        check("t1_idle", 32'(busy), 0);
        cyc(0, 0);
        check("t1_done_clr", 32'(pkt_done), 0);

        // Packet 0,0100,1100 with sink 0 stalled after the 2nd payload bit; sink 1 ignored.
        sif.y1_ready = 1'b0;
        cyc(1, 0);
        check("t2_sel", 32'(sel), 0);
        len4 = 4'b0100;
        for (int i = 3; i >= 0; i--) cyc(1, len4[i]);
        cyc(1, 1);
        check("t2_b0_rdy", 32'(s_rdy), 1);
        check("t2_b0_y0d", 32'(s_y0d), 1);
        cyc(1, 1);
        check("t2_b1_y0d", 32'(s_y0d), 1);
        sif.y0_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0);
            check("t2_stall_rdy", 32'(s_rdy), 0);
            check("t2_stall_y0v", 32'(s_y0v), 1);
            check("t2_stall_busy", 32'(busy), 1);
            check("t2_stall_done", 32'(pkt_done), 0);
        end
        sif.y0_ready = 1'b1;
        cyc(1, 0);
        check("t2_b2_rdy", 32'(s_rdy), 1);
        check("t2_b2_y0d", 32'(s_y0d), 0);
        check("t2_b2_done", 32'(pkt_done), 0);
        cyc(1, 0);
        check("t2_b3_y0v", 32'(s_y0v), 1);
        check("t2_b3_y1v", 32'(s_y1v), 0);
        check("t2_done", 32'(pkt_done), 1);
        check("t2_cnt0", 32'(pkt_cnt0), 1);
        check("t2_cnt1", 32'(pkt_cnt1), 1);
        sif.y1_ready = 1'b1;

        // Zero-length packet 1,0000.
        cyc(1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0);
            check("t3_y1v", 32'(s_y1v), 0);
        end
        check("t3_done", 32'(pkt_done), 1);
        check("t3_cnt1", 32'(pkt_cnt1), 2);
        check("t3_busy", 32'(busy), 0);

        // Next bit is a destination: 0,0011,1 then flush.
        cyc(1, 0);
        check("t4_done_clr", 32'(pkt_done), 0);
        check("t4_sel", 32'(sel), 0);
        check("t4_busy", 32'(busy), 1);
        len4 = 4'b0011;
        for (int i = 3; i >= 0; i--) cyc(1, len4[i]);
        cyc(1, 1);
        check("t4_y0d", 32'(s_y0d), 1);
        flush = 1'b1;
        cyc(1, 0);
        flush = 1'b0;
        check("t4_flush_rdy", 32'(s_rdy), 1);
        check("t4_flush_busy", 32'(busy), 0);
        check("t4_flush_done", 32'(pkt_done), 0);
        check("t4_flush_cnt0", 32'(pkt_cnt0), 1);
        check("t4_flush_sel", 32'(sel), 0);
        cyc(1, 1);
        check("t4_sel1", 32'(sel), 1);
        len4 = 4'b0001;
        for (int i = 3; i >= 0; i--) cyc(1, len4[i]);
        cyc(1, 1);
        check("t4_y1v", 32'(s_y1v), 1);
        check("t4_y1d", 32'(s_y1d), 1);
        check("t4_y0v", 32'(s_y0v), 0);
        check("t4_done", 32'(pkt_done), 1);
        check("t4_cnt1", 32'(pkt_cnt1), 3);
        check("t4_cnt0", 32'(pkt_cnt0), 1);

        // Async reset in the middle of a payload.
        cyc(1, 1);
        len4 = 4'b0011;
        for (int i = 3; i >= 0; i--) cyc(1, len4[i]);
        cyc(1, 1);
        sif.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_sel", 32'(sel), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(pkt_done), 0);
        check("t5_cnt0", 32'(pkt_cnt0), 0);
        check("t5_cnt1", 32'(pkt_cnt1), 0);
        check("t5_rdy", 32'(sif.in_ready), 1);
        check("t5_y1v", 32'(sif.y1_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 0);
        len4 = 4'b0010;
        for (int i = 3; i >= 0; i--) cyc(1, len4[i]);
        cyc(1, 1);
        check("t5_b0_y0d", 32'(s_y0d), 1);
        cyc(1, 0);
        check("t5_b1_y0v", 32'(s_y0v), 1);
        check("t5_b1_y0d", 32'(s_y0d), 0);
        check("t5_pkt_done", 32'(pkt_done), 1);
        check("t5_cnt0_after", 32'(pkt_cnt0), 1);
        check("t5_cnt1_after", 32'(pkt_cnt1), 0);
        cyc(0, 0);

        // Counter wrap with CNT_W=2: five zero-length packets to output 0.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 5; i++) cyc2(1, 0);
            check("t6_done", 32'(pkt_done2), 1);
            check("t6_cnt0", 32'(pkt_cnt0_2), 32'(wrap_exp[k]));
        end
        check("t6_cnt1", 32'(pkt_cnt1_2), 0);
        cyc2(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
